// File: rtl/local_port_buffered.sv
// local_port_buffered: ring-router local eject/inject stage; optional LOCAL_INJ_STARVE_EN starvation override on channel NUM_CH-1
module local_port_buffered #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 64,
   parameter int VALID_POS  = 63,
   parameter int TIME_LSB   = 40,
   parameter int TIME_WIDTH = 8,
   parameter int PPV_LSB    = 32,
   parameter int INJ_DEPTH  = 4,
   parameter int EJ_DEPTH   = 4,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_flit,
   input  logic [NUM_CH-1:0]            merge,
   input  logic [DATA_WIDTH-1:0]        inj_flit,
   input  logic                         inj_valid,
   output logic                         inj_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_flit,
   output logic [DATA_WIDTH-1:0]        ej_flit,
   output logic                         ej_valid,
   input  logic                         ej_ready,
   output logic [CNT_WIDTH-1:0]         num_flit_o
);
   localparam int IW = $clog2(INJ_DEPTH);
   localparam int EW = $clog2(EJ_DEPTH);
   localparam int CW = $clog2(NUM_CH);
   localparam int MAXC = (1 << CNT_WIDTH) - 1;
   logic [DATA_WIDTH-1:0] inj_mem [INJ_DEPTH];
   logic [DATA_WIDTH-1:0] ej_mem [EJ_DEPTH];
   logic [IW-1:0] inj_wr, inj_rd;
   logic [IW:0] inj_cnt;
   logic [EW-1:0] ej_wr, ej_rd;
   logic [EW:0] ej_cnt;
   logic [NUM_CH-1:0] cand, free;
   logic found, ej_space, inj_ne, do_ej, do_inj, freed_one, inj_push, ej_pop;
   logic force_ej, force_free;
   logic [CW-1:0] win, win_e, inj_ch;
   logic [TIME_WIDTH-1:0] best;
   logic [DATA_WIDTH-1:0] ej_data, fwd;
   logic [NUM_CH*DATA_WIDTH-1:0] out_next;
   logic [CNT_WIDTH-1:0] num_next;
   int n;
   assign inj_ne    = inj_cnt != '0;
   assign ej_space  = ej_cnt < (EW+1)'(EJ_DEPTH);
   assign inj_ready = rst_n & (inj_cnt < (IW+1)'(INJ_DEPTH));
   assign inj_push  = inj_valid & inj_ready;
   assign ej_valid  = ej_cnt != '0;
   assign ej_pop    = ej_valid & ej_ready;
   assign ej_flit   = ej_mem[ej_rd];
   always_comb begin
      cand = '0;
      found = 1'b0;
      win = '0;
      best = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         cand[c] = in_flit[c*DATA_WIDTH+VALID_POS] & in_flit[c*DATA_WIDTH+PPV_LSB+4] & ~merge[c];
         if (cand[c] && (!found || in_flit[c*DATA_WIDTH+TIME_LSB +: TIME_WIDTH] < best)) begin
            found = 1'b1;
            win = CW'(c);
            best = in_flit[c*DATA_WIDTH+TIME_LSB +: TIME_WIDTH];
         end
      end
   end
`ifdef LOCAL_INJ_STARVE_EN
   logic [3:0] starve_cnt;
   logic starve;
   assign starve     = (starve_cnt == 4'd15) & inj_ne;
   assign force_ej   = starve & cand[NUM_CH-1] & ej_space;
   assign force_free = starve & (~cand[NUM_CH-1] | ej_space);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) starve_cnt <= '0;
      else starve_cnt <= (!inj_ne || do_inj) ? 4'd0 : (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
`else
   assign force_ej   = 1'b0;
   assign force_free = 1'b0;
`endif
   always_comb begin
      win_e = force_ej ? CW'(NUM_CH-1) : win;
      do_ej = (found | force_ej) & ej_space;
      ej_data = in_flit[win_e*DATA_WIDTH +: DATA_WIDTH];
      fwd = ej_data & ~(DATA_WIDTH'(1) << (PPV_LSB+4));
      freed_one = do_ej & (ej_data[PPV_LSB +: 4] == 4'd0);
      free = '0;
      inj_ch = '0;
      for (int c = NUM_CH-1; c >= 0; c--) begin
         free[c] = ~in_flit[c*DATA_WIDTH+VALID_POS] | merge[c] | (freed_one && win_e == CW'(c)) | (force_free && c == NUM_CH-1);
         if (free[c]) inj_ch = CW'(c);
      end
      do_inj = inj_ne & (|free);
      out_next = '0;
      for (int c = 0; c < NUM_CH; c++)
         out_next[c*DATA_WIDTH +: DATA_WIDTH] = (do_inj && inj_ch == CW'(c)) ? inj_mem[inj_rd] :
            (merge[c] || (freed_one && win_e == CW'(c))) ? '0 :
            (do_ej && win_e == CW'(c)) ? fwd : in_flit[c*DATA_WIDTH +: DATA_WIDTH];
      n = int'(num_flit_o) + int'(do_inj) - int'(freed_one) - $countones(merge);
      num_next = (n < 0) ? '0 : (n > MAXC) ? '1 : CNT_WIDTH'(n);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_flit <= '0;
         num_flit_o <= '0;
         inj_wr <= '0;
         inj_rd <= '0;
         inj_cnt <= '0;
         ej_wr <= '0;
         ej_rd <= '0;
         ej_cnt <= '0;
      end else begin
         out_flit <= out_next;
         num_flit_o <= num_next;
         inj_wr <= inj_wr + IW'(inj_push);
         inj_rd <= inj_rd + IW'(do_inj);
         inj_cnt <= inj_cnt + (IW+1)'(inj_push) - (IW+1)'(do_inj);
         ej_wr <= ej_wr + EW'(do_ej);
         ej_rd <= ej_rd + EW'(ej_pop);
         ej_cnt <= ej_cnt + (EW+1)'(do_ej) - (EW+1)'(ej_pop);
      end
   always_ff @(posedge clk) begin
      if (inj_push) inj_mem[inj_wr] <= inj_flit;
      if (do_ej) ej_mem[ej_wr] <= ej_data;
   end
endmodule
